// File: rtl/cg_pkg.sv
// ---------------------------------------------------------------------------
// cg_pkg
// Shared definitions for the coilgun event monitor:
//   - bit positions of the sticky event-flag register
//   - measurement FSM state encoding (IDLE / MEAS)
//   - event-flag register type
// ---------------------------------------------------------------------------
package cg_pkg;

    // Event-flag bit positions. Bit 7 is reserved and always reads 0.
    localparam int EF_TRIG   = 0;  // trigger accepted, measurement started
    localparam int EF_GATE   = 1;  // any debounced gate rise
    localparam int EF_TOF    = 2;  // time-of-flight captured
    localparam int EF_TMO    = 3;  // measurement abandoned on timeout
    localparam int EF_EARLY  = 4;  // gate seen while no measurement running
    localparam int EF_RETRIG = 5;  // trigger seen while already measuring
    localparam int EF_EXTON  = 6;  // coil still driven when the gate fired

    localparam logic [7:0] EF_IMPL_MASK = 8'h7F;

    // Measurement FSM encoding.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MEAS = 1'b1;

    typedef logic [7:0] eflg_t;

endpackage

// File: rtl/cg_debounce.sv
// ---------------------------------------------------------------------------
// cg_debounce
// Synchronizer + debouncer + rising-edge pulse for one raw asynchronous input.
//
// Ports:
//   I_clk    in   master clock
//   I_rst_n  in   asynchronous active-low reset
//   I_raw    in   raw asynchronous input
//   O_level  out  debounced level
//   O_rise   out  one-cycle pulse, high in the same cycle O_level goes 0->1
//
// The level changes once the synchronized input has disagreed with it for
// DB_CYCLES consecutive cycles; any agreeing cycle restarts the count, so
// shorter glitches never reach the output.
// ---------------------------------------------------------------------------
module cg_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_raw,
    output logic O_level,
    output logic O_rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   sync_val;

    assign sync_val = sync_q[SYNC_STAGES-1];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            O_level <= 1'b0;
            O_rise  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I_raw};
            O_rise <= 1'b0;
            if (sync_val == O_level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // This is the DB_CYCLES-th consecutive disagreeing cycle.
                O_level <= sync_val;
                O_rise  <= sync_val;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cg_event_monitor.sv
// ---------------------------------------------------------------------------
// cg_event_monitor
// Input conditioner and event monitor for the coilgun controller. Cleans the
// trigger and gate inputs, measures trigger-to-gate time of flight and keeps
// the sticky event-flag register read by the host.
//
// Ports:
//   I_clk, I_rst_n     clock, asynchronous active-low reset
//   I_trig, I_gate     raw asynchronous trigger / gate sensor inputs
//   I_ext              coil-drive-active feedback from the coil core
//   I_eclr, I_eclr_stb write-1-to-clear mask for O_eflg, qualified by strobe
//   O_trig, O_gate     debounced levels
//   O_trig_rise        one-cycle pulse per debounced trigger rising edge
//   O_gate_rise        one-cycle pulse per debounced gate rising edge
//   O_eflg             sticky event flags (bit 7 reads 0)
//   O_tof, O_tof_vld   last valid time of flight in cycles, update pulse
//   O_state            measurement FSM state (ST_IDLE / ST_MEAS), debug view
//
// Handshake semantics: there is no back-pressure anywhere. I_eclr_stb is a
// single-cycle valid for I_eclr, acted on in the cycle it is high; O_tof_vld
// is a single-cycle valid for O_tof, which holds until the next capture.
// A flag set and a clear of the same bit in one cycle leave the bit set.
// ---------------------------------------------------------------------------
module cg_event_monitor
    import cg_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          DB_CYCLES   = 16,
    parameter logic [23:0] TIMEOUT     = 24'd1000000
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_trig,
    input  logic        I_gate,
    input  logic        I_ext,
    input  logic [7:0]  I_eclr,
    input  logic        I_eclr_stb,
    output logic        O_trig,
    output logic        O_gate,
    output logic        O_trig_rise,
    output logic        O_gate_rise,
    output logic [7:0]  O_eflg,
    output logic [23:0] O_tof,
    output logic        O_tof_vld,
    output logic        O_state
);

    logic        state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    eflg_t       ev_set;
    eflg_t       clr_mask;
    eflg_t       eflg_d;
    logic        tof_load;

    cg_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_trig (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_raw   (I_trig),
        .O_level (O_trig),
        .O_rise  (O_trig_rise)
    );

    cg_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_gate (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_raw   (I_gate),
        .O_level (O_gate),
        .O_rise  (O_gate_rise)
    );

    // cnt counts cycles since the trigger pulse: it is 1 the cycle after the
    // pulse, so a gate pulse N cycles after the trigger pulse captures N.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ev_set   = '0;
        tof_load = 1'b0;

        if (O_gate_rise) begin
            ev_set[EF_GATE]  = 1'b1;
            ev_set[EF_EXTON] = I_ext;
        end

        if (state_q == ST_IDLE) begin
            if (O_gate_rise) begin
                ev_set[EF_EARLY] = 1'b1;
            end
            if (O_trig_rise) begin
                ev_set[EF_TRIG] = 1'b1;
                state_d         = ST_MEAS;
                cnt_d           = 24'd1;
            end
        end else begin
            // A gate completes the running measurement even if a trigger
            // arrives in the same cycle; the trigger then restarts it.
            if (O_gate_rise) begin
                tof_load       = 1'b1;
                ev_set[EF_TOF] = 1'b1;
                state_d        = ST_IDLE;
            end
            if (O_trig_rise) begin
                ev_set[EF_RETRIG] = 1'b1;
                state_d           = ST_MEAS;
                cnt_d             = 24'd1;
            end else if (!O_gate_rise) begin
                if (cnt_q == TIMEOUT) begin
                    ev_set[EF_TMO] = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
        end
    end

    assign clr_mask = I_eclr_stb ? I_eclr : 8'h00;
    // Setting is applied after clearing so a same-cycle event wins.
    assign eflg_d   = ((O_eflg & ~clr_mask) | ev_set) & EF_IMPL_MASK;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            O_eflg    <= '0;
            O_tof     <= '0;
            O_tof_vld <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            O_eflg    <= eflg_d;
            O_tof_vld <= tof_load;
            if (tof_load) begin
                O_tof <= cnt_q;
            end
        end
    end

    assign O_state = state_q;

endmodule

// File: tb/tb_cg_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_cg_event_monitor
// Directed + randomized bench for cg_event_monitor (SYNC_STAGES=2,
// DB_CYCLES=4, TIMEOUT=100). The reference model works at event level: each
// clean raw edge becomes a debounced pulse LAT cycles later, and the flag /
// time-of-flight rules are applied to those pulse times directly.
// ---------------------------------------------------------------------------
module tb_cg_event_monitor;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int TMO  = 100;
  localparam int LAT  = SYNC + DB;
  localparam int HOLD = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_trig = 1'b0;
  logic        I_gate = 1'b0;
  logic        I_ext = 1'b0;
  logic [7:0]  I_eclr = 8'h00;
  logic        I_eclr_stb = 1'b0;
  logic        O_trig, O_gate, O_trig_rise, O_gate_rise, O_tof_vld, O_state;
  logic [7:0]  O_eflg;
  logic [23:0] O_tof;

  cg_event_monitor #(
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .TIMEOUT     (24'(TMO))
  ) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_trig      (I_trig),
    .I_gate      (I_gate),
    .I_ext       (I_ext),
    .I_eclr      (I_eclr),
    .I_eclr_stb  (I_eclr_stb),
    .O_trig      (O_trig),
    .O_gate      (O_gate),
    .O_trig_rise (O_trig_rise),
    .O_gate_rise (O_gate_rise),
    .O_eflg      (O_eflg),
    .O_tof       (O_tof),
    .O_tof_vld   (O_tof_vld),
    .O_state     (O_state)
  );

  always #5 I_clk = ~I_clk;

  // Cycle counter and observed pulse counts.
  int cyc = 0;
  int n_trig = 0;
  int n_gate = 0;
  int n_vld = 0;

  always @(posedge I_clk) begin
    cyc <= cyc + 1;
    if (O_trig_rise) n_trig <= n_trig + 1;
    if (O_gate_rise) n_gate <= n_gate + 1;
    if (O_tof_vld)   n_vld  <= n_vld + 1;
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_flags;
  int          m_last_set[8];
  logic [23:0] m_tof;
  int          m_vld, m_trig, m_gate;
  bit          m_meas;
  int          m_start;

  function automatic void model_reset();
    m_flags = 8'h00;
    m_tof   = 24'd0;
    m_meas  = 1'b0;
    m_start = 0;
    for (int i = 0; i < 8; i++) m_last_set[i] = -1;
  endfunction

  function automatic void set_flag(int i, int t);
    m_flags[i] = 1'b1;
    if (t > m_last_set[i]) m_last_set[i] = t;
  endfunction

  // A measurement started by a pulse at m_start times out at cycle
  // m_start+TMO unless some pulse arrives by then.
  function automatic void model_expire(int p);
    if (m_meas && (m_start + TMO < p)) begin
      set_flag(3, m_start + TMO);
      m_meas = 1'b0;
    end
  endfunction

  function automatic void model_events(int p, bit t, bit g, bit e);
    bit was_meas;
    model_expire(p);
    was_meas = m_meas;
    if (g) begin
      m_gate++;
      set_flag(1, p);
      if (e) set_flag(6, p);
      if (was_meas) begin
        m_tof = 24'(p - m_start);
        m_vld++;
        set_flag(2, p);
        m_meas = 1'b0;
      end else begin
        set_flag(4, p);
      end
    end
    if (t) begin
      m_trig++;
      set_flag(was_meas ? 5 : 0, p);
      m_meas  = 1'b1;
      m_start = p;
    end
  endfunction

  // Clear in cycle q: a bit survives if it was (re)set in cycle q or later.
  function automatic void model_clear(int q, logic [7:0] mask);
    model_expire(q + 1);
    for (int i = 0; i < 8; i++)
      if (mask[i] && (m_last_set[i] < q)) m_flags[i] = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  int trig_rel = -1;
  int gate_rel = -1;
  int ext_rel  = -1;

  task automatic adv(int n);
    repeat (n) begin
      @(negedge I_clk);
      if (cyc == trig_rel) I_trig = 1'b0;
      if (cyc == gate_rel) I_gate = 1'b0;
      if (cyc == ext_rel)  I_ext  = 1'b0;
    end
  endtask

  task automatic fire(bit t, bit g, bit e, int hold);
    if (t) begin
      I_trig   = 1'b1;
      trig_rel = cyc + hold;
    end
    if (g) begin
      I_gate   = 1'b1;
      gate_rel = cyc + hold;
      I_ext    = e;
      ext_rel  = cyc + hold;
    end
    model_events(cyc + LAT, t, g, e);
  endtask

  task automatic clear(logic [7:0] mask);
    I_eclr     = mask;
    I_eclr_stb = 1'b1;
    model_clear(cyc, mask);
    adv(1);
    I_eclr_stb = 1'b0;
    I_eclr     = 8'h00;
  endtask

  task automatic check_state(string tag);
    model_expire(cyc);
    chk({tag, "_eflg"},  32'(O_eflg),  32'(m_flags));
    chk({tag, "_tof"},   32'(O_tof),   32'(m_tof));
    chk({tag, "_nvld"},  32'(n_vld),   32'(m_vld));
    chk({tag, "_state"}, 32'(O_state), 32'(m_meas));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  d, n, gap, kind;
    bit  e, saw;
    logic [7:0] mask;

    model_reset();
    m_vld  = 0;
    m_trig = 0;
    m_gate = 0;

    // Reset values
    adv(3);
    chk("rst_trig",      32'(O_trig),      32'd0);
    chk("rst_gate",      32'(O_gate),      32'd0);
    chk("rst_trig_rise", 32'(O_trig_rise), 32'd0);
    chk("rst_gate_rise", 32'(O_gate_rise), 32'd0);
    chk("rst_eflg",      32'(O_eflg),      32'd0);
    chk("rst_tof",       32'(O_tof),       32'd0);
    chk("rst_tof_vld",   32'(O_tof_vld),   32'd0);
    chk("rst_state",     32'(O_state),     32'd0);
    I_rst_n = 1'b1;
    adv(5);

    // Clean trigger, gate 50 cycles later
    d = cyc;
    fire(1'b1, 1'b0, 1'b0, HOLD);
    adv(LAT - 1);
    chk("s1_trig_early",  32'(O_trig),      32'd0);
    chk("s1_rise_early",  32'(O_trig_rise), 32'd0);
    adv(1);
    chk("s1_trig_level",  32'(O_trig),      32'd1);
    chk("s1_trig_pulse",  32'(O_trig_rise), 32'd1);
    chk("s1_eflg_pre",    32'(O_eflg),      32'd0);
    adv(1);
    chk("s1_pulse_width", 32'(O_trig_rise), 32'd0);
    chk("s1_eflg_trig",   32'(O_eflg),      32'h01);
    chk("s1_state_meas",  32'(O_state),     32'd1);
    adv(50 - 7);
    fire(1'b0, 1'b1, 1'b0, HOLD);
    adv(LAT);
    chk("s1_gate_pulse",  32'(O_gate_rise), 32'd1);
    chk("s1_vld_pre",     32'(O_tof_vld),   32'd0);
    adv(1);
    chk("s1_vld",         32'(O_tof_vld),   32'd1);
    chk("s1_tof",         32'(O_tof),       32'd50);
    adv(1);
    chk("s1_vld_width",   32'(O_tof_vld),   32'd0);
    adv(5);
    check_state("s1");
    chk("s1_eflg_07",     32'(O_eflg),      32'h07);
    chk("s1_ntrig",       32'(n_trig),      32'(m_trig));
    chk("s1_ngate",       32'(n_gate),      32'(m_gate));
    clear(8'hFF);
    adv(2);
    check_state("s1_clr");
    adv(20);

    // Trigger with no gate: timeout
    fire(1'b1, 1'b0, 1'b0, HOLD);
    adv(LAT + TMO);
    check_state("tmo_pre");
    adv(1);
    check_state("tmo_post");
    chk("tmo_flag",     32'(O_eflg[3]), 32'd1);
    chk("tmo_tof_kept", 32'(O_tof),     32'd50);
    chk("tmo_idle",     32'(O_state),   32'd0);
    clear(8'hFF);
    adv(20);

    // Short gate glitch, then a 6-cycle gate pulse in IDLE
    I_gate   = 1'b1;
    gate_rel = cyc + 3;
    saw = 1'b0;
    repeat (15) begin
      adv(1);
      if (O_gate || O_gate_rise) saw = 1'b1;
    end
    chk("glitch_level",  32'(saw),    32'd0);
    chk("glitch_pulses", 32'(n_gate), 32'(m_gate));
    fire(1'b0, 1'b1, 1'b0, 6);
    adv(LAT - 1);
    chk("gate6_early",   32'(O_gate),      32'd0);
    adv(1);
    chk("gate6_level",   32'(O_gate),      32'd1);
    chk("gate6_pulse",   32'(O_gate_rise), 32'd1);
    adv(10);
    check_state("early");
    chk("early_eflg",    32'(O_eflg),      32'h12);
    clear(8'hFF);
    adv(20);

    // Retrigger: measurement restarts from the second trigger
    gap = $urandom_range(20, 40);
    n   = $urandom_range(10, 90);
    fire(1'b1, 1'b0, 1'b0, HOLD);
    adv(gap);
    fire(1'b1, 1'b0, 1'b0, HOLD);
    adv(n);
    fire(1'b0, 1'b1, 1'b0, HOLD);
    adv(LAT + 4);
    check_state("retrig");
    chk("retrig_tof",  32'(O_tof),  32'(n));
    chk("retrig_eflg", 32'(O_eflg), 32'h27);
    clear(8'hFF);
    adv(20);

    // Gate while coil driven; clear racing a new EXTON event
    fire(1'b1, 1'b0, 1'b0, HOLD);
    adv(30);
    fire(1'b0, 1'b1, 1'b1, HOLD);
    adv(LAT + 4);
    check_state("ext");
    chk("ext_flag", 32'(O_eflg[6]), 32'd1);
    adv(20);
    fire(1'b1, 1'b0, 1'b0, HOLD);
    adv(30);
    fire(1'b0, 1'b1, 1'b1, HOLD);
    adv(LAT);
    clear(8'h40);
    adv(4);
    check_state("ext_setwins");
    chk("ext_setwins_bit", 32'(O_eflg[6]), 32'd1);
    adv(10);
    clear(8'h40);
    adv(2);
    chk("ext_clr_bit", 32'(O_eflg[6]), 32'd0);
    check_state("ext_clr");
    adv(20);

    // Reset in the middle of a measurement
    fire(1'b1, 1'b0, 1'b0, HOLD);
    adv(25);
    chk("mrst_meas", 32'(O_state), 32'd1);
    I_rst_n = 1'b0;
    #1;
    chk("mrst_state", 32'(O_state), 32'd0);
    chk("mrst_eflg",  32'(O_eflg),  32'd0);
    chk("mrst_tof",   32'(O_tof),   32'd0);
    chk("mrst_trig",  32'(O_trig),  32'd0);
    model_reset();
    adv(3);
    I_rst_n = 1'b1;
    adv(5);
    fire(1'b0, 1'b1, 1'b0, HOLD);
    adv(LAT + 4);
    check_state("post_rst");
    chk("post_rst_eflg", 32'(O_eflg), 32'h12);
    adv(20);

    // Randomized measurements, including simultaneous edges and
    // gates landing exactly on / just past the timeout.
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 1);
      e    = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        n = $urandom_range(0, 101);
        if (i == 0) n = 0;
        if (i == 1) n = TMO;
        if (i == 2) n = TMO + 1;
        if (n == 0) begin
          fire(1'b1, 1'b1, e, HOLD);
        end else begin
          fire(1'b1, 1'b0, 1'b0, HOLD);
          adv(n);
          fire(1'b0, 1'b1, e, HOLD);
        end
      end else begin
        gap = $urandom_range(20, 40);
        n   = $urandom_range(1, 90);
        fire(1'b1, 1'b0, 1'b0, HOLD);
        adv(gap);
        fire(1'b1, 1'b0, 1'b0, HOLD);
        adv(n);
        fire(1'b0, 1'b1, e, HOLD);
      end
      adv(LAT + 4);
      check_state($sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_ntrig", i), 32'(n_trig), 32'(m_trig));
      chk($sformatf("rnd%0d_ngate", i), 32'(n_gate), 32'(m_gate));
      mask = 8'($urandom_range(0, 255));
      clear(mask);
      adv(TMO + 20);
      check_state($sformatf("rnd%0d_clr", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
